// File: rtl/tr_pkg.sv
// Shared TR-domain definitions: sequencer state encoding, edge-history codes
// and the trigger qualification rule.
package tr_pkg;

   typedef logic [1:0] tr_state_t;

   localparam tr_state_t IDLE    = 2'd0;
   localparam tr_state_t DELAY   = 2'd1;
   localparam tr_state_t ACTIVE  = 2'd2;
   localparam tr_state_t HOLDOFF = 2'd3;

   // Edge history is {previous, current} of the filtered TR level.
   localparam logic [1:0] EDGE_FALL = 2'b10;
   localparam logic [1:0] EDGE_RIN  = 2'b01;

   // The current TR level must agree with the newest history bit, otherwise no edge.
   function automatic logic is_trigger(input logic [1:0] edge_hist,
                                       input logic       sel_rise,
                                       input logic       level);
      return (edge_hist == (sel_rise ? EDGE_RIN : EDGE_FALL)) && (edge_hist[0] == level);
   endfunction

endpackage

// File: rtl/tr_pulse_gen_if.sv
// Signal bundle between the TR synchronizer side and tr_pulse_gen.
// pulse_cnt exists only when TR_PULSE_COUNT_EN is defined.
interface tr_pulse_gen_if #(
   parameter int DLY_W = 16,
   parameter int WID_W = 16
);

   logic             tr;
   logic [1:0]       tr_edge;
   logic             trig_sel;
   logic [DLY_W-1:0] delay_cyc;
   logic [WID_W-1:0] width_cyc;
   logic             pulse_out;
   logic             busy;
   logic             missed;
`ifdef TR_PULSE_COUNT_EN
   logic [15:0]      pulse_cnt;
`endif

   modport master (
      output tr, tr_edge, trig_sel, delay_cyc, width_cyc,
`ifdef TR_PULSE_COUNT_EN
      input  pulse_cnt,
`endif
      input  pulse_out, busy, missed
   );

   modport slave (
      input  tr, tr_edge, trig_sel, delay_cyc, width_cyc,
`ifdef TR_PULSE_COUNT_EN
      output pulse_cnt,
`endif
      output pulse_out, busy, missed
   );

endinterface

// File: rtl/tr_down_counter.sv
// Loadable down counter that holds at zero; load has priority over decrement.
module tr_down_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tr_pulse_gen.sv
// TR trigger-to-pulse sequencer: edge -> delay -> gated pulse -> hold-off.
// Define TR_PULSE_COUNT_EN to add the completed-pulse counter (pulse_cnt).
module tr_pulse_gen
   import tr_pkg::*;
#(
   parameter int DLY_W    = 16,
   parameter int WID_W    = 16,
   parameter int HOLD_CYC = 4
) (
   input  logic          clk,
   input  logic          rst,
   tr_pulse_gen_if.slave bus
);

   localparam int              HLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [HLD_W-1:0] HLD_LOAD = HLD_W'(HOLD_CYC - 1);

   tr_state_t        state_q, state_d;
   logic             pulse_q, pulse_d;
   logic             missed_q, missed_d;
   logic             trig;
   logic             arm;
   logic             dly_dec, dly_zero;
   logic             wid_dec, wid_zero;
   logic             hld_load, hld_dec, hld_zero;
   logic [DLY_W-1:0] dly_init;

   assign trig     = is_trigger(bus.tr_edge, bus.trig_sel, bus.tr);
   // Delay and hold-off counters run to zero inclusive, so they load N-1 for N cycles.
   assign dly_init = bus.delay_cyc - DLY_W'(1);

   tr_down_counter #(.W(DLY_W)) u_dly_cnt (
      .clk        (clk),
      .rst_n      (rst),
      .load_i     (arm),
      .load_val_i (dly_init),
      .dec_i      (dly_dec),
      .zero_o     (dly_zero)
   );

   // The width counter also serves as the latched W until ACTIVE starts consuming it.
   tr_down_counter #(.W(WID_W)) u_wid_cnt (
      .clk        (clk),
      .rst_n      (rst),
      .load_i     (arm),
      .load_val_i (bus.width_cyc),
      .dec_i      (wid_dec),
      .zero_o     (wid_zero)
   );

   tr_down_counter #(.W(HLD_W)) u_hld_cnt (
      .clk        (clk),
      .rst_n      (rst),
      .load_i     (hld_load),
      .load_val_i (HLD_LOAD),
      .dec_i      (hld_dec),
      .zero_o     (hld_zero)
   );

   always_comb begin
      state_d  = state_q;
      pulse_d  = 1'b0;
      missed_d = trig && (state_q != IDLE);
      arm      = 1'b0;
      dly_dec  = 1'b0;
      wid_dec  = 1'b0;
      hld_load = 1'b0;
      hld_dec  = 1'b0;
      case (state_q)
         IDLE: begin
            if (trig) begin
               arm = 1'b1;
               if (bus.delay_cyc != '0) begin
                  state_d = DELAY;
               end else if (bus.width_cyc != '0) begin
                  state_d = ACTIVE;
               end else begin
                  state_d  = HOLDOFF;
                  hld_load = 1'b1;
               end
            end
         end
         DELAY: begin
            if (dly_zero) begin
               if (wid_zero) begin
                  state_d  = HOLDOFF;
                  hld_load = 1'b1;
               end else begin
                  state_d = ACTIVE;
               end
            end else begin
               dly_dec = 1'b1;
            end
         end
         ACTIVE: begin
            // First ACTIVE cycle only primes the registered output, hence W+1 cycles here.
            if (wid_zero) begin
               state_d  = HOLDOFF;
               hld_load = 1'b1;
            end else begin
               pulse_d = 1'b1;
               wid_dec = 1'b1;
            end
         end
         HOLDOFF: begin
            if (hld_zero) begin
               state_d = IDLE;
            end else begin
               hld_dec = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         pulse_q  <= 1'b0;
         missed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pulse_q  <= pulse_d;
         missed_q <= missed_d;
      end
   end

   assign bus.pulse_out = pulse_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.missed    = missed_q;

`ifdef TR_PULSE_COUNT_EN
   logic [15:0] cnt_q;
   logic        cnt_inc;

   assign cnt_inc = (state_q == ACTIVE) && wid_zero;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (cnt_inc) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign bus.pulse_cnt = cnt_q;
`endif

endmodule
